// File: rtl/slot_payout_engine.sv
// Slot machine spin controller: takes the bet on a button press, waits for the
// reels to settle after release, latches and classifies the symbols, then
// credits the payout. Also keeps the balance and spin/win statistics.
module slot_payout_engine #(
  parameter int CREDIT_W      = 16,
  parameter int START_CREDITS = 1000,
  parameter int BET           = 10,
  parameter int PAY_PAIR      = 50,
  parameter int PAY_TRIPLE    = 500,
  parameter int PAY_JACKPOT   = 5000,
  parameter int SETTLE_CYCLES = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_press,
  input  logic [2:0]          rng1,
  input  logic [2:0]          rng2,
  input  logic [2:0]          rng3,
  output logic [CREDIT_W-1:0] credits,
  output logic [2:0]          reel1,
  output logic [2:0]          reel2,
  output logic [2:0]          reel3,
  output logic [1:0]          win_code,
  output logic [CREDIT_W-1:0] payout,
  output logic                spin_active,
  output logic                result_valid,
  output logic                insufficient,
  output logic [15:0]         spin_count,
  output logic [15:0]         win_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CREDIT_W-1:0] L_START   = CREDIT_W'(START_CREDITS);
  localparam logic [CREDIT_W-1:0] L_BET     = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] L_PAIR    = CREDIT_W'(PAY_PAIR);
  localparam logic [CREDIT_W-1:0] L_TRIPLE  = CREDIT_W'(PAY_TRIPLE);
  localparam logic [CREDIT_W-1:0] L_JACKPOT = CREDIT_W'(PAY_JACKPOT);
  localparam logic [CNT_W-1:0]    L_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_SETTLE, S_EVAL} state_t;

  state_t              r_state;
  logic                r_btn_q;
  logic [CNT_W-1:0]    r_settle_cnt;
  logic [CREDIT_W-1:0] r_credits;
  logic [2:0]          r_reel1, r_reel2, r_reel3;
  logic [1:0]          r_win_code;
  logic [CREDIT_W-1:0] r_payout;
  logic                r_spin_active;
  logic                r_result_valid;
  logic                r_insufficient;
  logic [15:0]         r_spin_count;
  logic [15:0]         r_win_count;

  logic                w_press_edge;
  logic [1:0]          w_win_code;
  logic [CREDIT_W-1:0] w_payout;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credits_won;

  assign w_press_edge  = button_press & ~r_btn_q;
  assign w_sum         = {1'b0, r_credits} + {1'b0, r_payout};
  assign w_credits_won = w_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];

  // Classify the live reel symbols; only captured when the reels are latched.
  always_comb begin
    w_win_code = 2'd0;
    w_payout   = '0;
    if (rng1 == rng2 && rng2 == rng3) begin
      if (rng1 == 3'b111) begin
        w_win_code = 2'd3;
        w_payout   = L_JACKPOT;
      end else begin
        w_win_code = 2'd2;
        w_payout   = L_TRIPLE;
      end
    end else if (rng1 == rng2 || rng2 == rng3 || rng1 == rng3) begin
      w_win_code = 2'd1;
      w_payout   = L_PAIR;
    end
  end

  // Spin FSM with registered outputs, balance and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_btn_q        <= 1'b0;
      r_settle_cnt   <= '0;
      r_credits      <= L_START;
      r_reel1        <= 3'd0;
      r_reel2        <= 3'd0;
      r_reel3        <= 3'd0;
      r_win_code     <= 2'd0;
      r_payout       <= '0;
      r_spin_active  <= 1'b0;
      r_result_valid <= 1'b0;
      r_insufficient <= 1'b0;
      r_spin_count   <= 16'd0;
      r_win_count    <= 16'd0;
    end else begin
      r_btn_q        <= button_press;
      r_result_valid <= 1'b0;
      r_insufficient <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press_edge) begin
            if (r_credits >= L_BET) begin
              r_credits     <= r_credits - L_BET;
              r_spin_count  <= r_spin_count + 16'd1;
              r_spin_active <= 1'b1;
              r_state       <= S_SPIN;
            end else begin
              r_insufficient <= 1'b1;
            end
          end
        end
        S_SPIN: begin
          if (!button_press) begin
            r_settle_cnt <= L_SETTLE;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_reel1        <= rng1;
            r_reel2        <= rng2;
            r_reel3        <= rng3;
            r_win_code     <= w_win_code;
            r_payout       <= w_payout;
            r_result_valid <= 1'b1;
            r_state        <= S_EVAL;
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
          end
        end
        S_EVAL: begin
          r_credits <= w_credits_won;
          if (r_win_code != 2'd0) begin
            r_win_count <= r_win_count + 16'd1;
          end
          r_spin_active <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign credits      = r_credits;
  assign reel1        = r_reel1;
  assign reel2        = r_reel2;
  assign reel3        = r_reel3;
  assign win_code     = r_win_code;
  assign payout       = r_payout;
  assign spin_active  = r_spin_active;
  assign result_valid = r_result_valid;
  assign insufficient = r_insufficient;
  assign spin_count   = r_spin_count;
  assign win_count    = r_win_count;

endmodule

// File: tb/tb_slot_payout_engine.sv
// Directed bench: three engines share clock, reset, button and reels.
// A uses defaults, B starts with 15 credits, C is 13 bits wide starting at 8000.
module tb_slot_payout_engine;

  localparam int N = 50;

  logic clk = 1'b0;
  logic reset, button;
  logic [2:0] rng1, rng2, rng3;

  logic [15:0] a_credits, a_payout, a_spin_count, a_win_count;
  logic [2:0]  a_reel1, a_reel2, a_reel3;
  logic [1:0]  a_win_code;
  logic        a_spin_active, a_result_valid, a_insufficient;

  logic [15:0] b_credits, b_payout, b_spin_count, b_win_count;
  logic [2:0]  b_reel1, b_reel2, b_reel3;
  logic [1:0]  b_win_code;
  logic        b_spin_active, b_result_valid, b_insufficient;

  logic [12:0] c_credits, c_payout;
  logic [15:0] c_spin_count, c_win_count;
  logic [2:0]  c_reel1, c_reel2, c_reel3;
  logic [1:0]  c_win_code;
  logic        c_spin_active, c_result_valid, c_insufficient;

  int n_vec = 0;
  int n_err = 0;
  int exp_a, exp_b, exp_c, exp_spins, exp_wins, exp_b_spins;

  always #5 clk = ~clk;

  slot_payout_engine #(.SETTLE_CYCLES(N)) u_a (
    .clk(clk), .reset(reset), .button_press(button),
    .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .credits(a_credits), .reel1(a_reel1), .reel2(a_reel2), .reel3(a_reel3),
    .win_code(a_win_code), .payout(a_payout), .spin_active(a_spin_active),
    .result_valid(a_result_valid), .insufficient(a_insufficient),
    .spin_count(a_spin_count), .win_count(a_win_count)
  );

  slot_payout_engine #(.START_CREDITS(15), .SETTLE_CYCLES(N)) u_b (
    .clk(clk), .reset(reset), .button_press(button),
    .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .credits(b_credits), .reel1(b_reel1), .reel2(b_reel2), .reel3(b_reel3),
    .win_code(b_win_code), .payout(b_payout), .spin_active(b_spin_active),
    .result_valid(b_result_valid), .insufficient(b_insufficient),
    .spin_count(b_spin_count), .win_count(b_win_count)
  );

  slot_payout_engine #(.CREDIT_W(13), .START_CREDITS(8000), .SETTLE_CYCLES(N)) u_c (
    .clk(clk), .reset(reset), .button_press(button),
    .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .credits(c_credits), .reel1(c_reel1), .reel2(c_reel2), .reel3(c_reel3),
    .win_code(c_win_code), .payout(c_payout), .spin_active(c_spin_active),
    .result_valid(c_result_valid), .insufficient(c_insufficient),
    .spin_count(c_spin_count), .win_count(c_win_count)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Idle reel value: a triple, so latching one cycle early or late shows up.
  task automatic junk_reels();
    rng1 = 3'd4; rng2 = 3'd4; rng3 = 3'd4;
  endtask

  task automatic spin(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                      input int code, input int pay);
    bit b_ok;
    b_ok = (exp_b >= 10);
    junk_reels();
    @(negedge clk); button = 1'b1;
    @(negedge clk);
    chk("a_active", a_spin_active, 1);
    chk("a_debit", a_credits, exp_a - 10);
    chk("a_spin_count", a_spin_count, exp_spins + 1);
    chk("b_insufficient", b_insufficient, b_ok ? 0 : 1);
    chk("b_active", b_spin_active, b_ok ? 1 : 0);
    @(negedge clk);
    chk("b_insuf_one_cycle", b_insufficient, 0);
    repeat (3) @(negedge clk);
    button = 1'b0;
    repeat (N) @(negedge clk);
    chk("rv_not_early", a_result_valid, 0);
    rng1 = r1; rng2 = r2; rng3 = r3;
    @(negedge clk);
    junk_reels();
    chk("rv_pulse", a_result_valid, 1);
    chk("reels", {a_reel1, a_reel2, a_reel3}, {r1, r2, r3});
    chk("win_code", a_win_code, code);
    chk("payout", a_payout, pay);
    chk("credits_before_win", a_credits, exp_a - 10);
    exp_a = exp_a - 10 + pay;
    if (exp_a > 65535) exp_a = 65535;
    exp_c = exp_c - 10 + pay;
    if (exp_c > 8191) exp_c = 8191;
    if (b_ok) begin
      exp_b = exp_b - 10 + pay;
      exp_b_spins++;
    end
    exp_spins++;
    if (code != 0) exp_wins++;
    @(negedge clk);
    chk("rv_cleared", a_result_valid, 0);
    chk("a_credits", a_credits, exp_a);
    chk("b_credits", b_credits, exp_b);
    chk("c_credits", c_credits, exp_c);
    chk("a_win_count", a_win_count, exp_wins);
    chk("b_spin_count", b_spin_count, exp_b_spins);
    chk("win_code_held", a_win_code, code);
    chk("a_idle", a_spin_active, 0);
    $display("spin %0d reels=%0d,%0d,%0d code=%0d payout=%0d credits A=%0d B=%0d C=%0d",
             exp_spins, r1, r2, r3, a_win_code, a_payout, a_credits, b_credits, c_credits);
  endtask

  initial begin
    int rv_seen;
    reset = 1'b1;
    button = 1'b0;
    junk_reels();
    repeat (3) @(negedge clk);
    chk("rst_a_credits", a_credits, 1000);
    chk("rst_b_credits", b_credits, 15);
    chk("rst_c_credits", c_credits, 8000);
    chk("rst_active", a_spin_active, 0);
    chk("rst_counts", {a_spin_count, a_win_count}, 0);
    chk("rst_result", {a_win_code, a_payout, a_result_valid, a_insufficient}, 0);
    reset = 1'b0;
    @(negedge clk);
    exp_a = 1000; exp_b = 15; exp_c = 8000;
    exp_spins = 0; exp_wins = 0; exp_b_spins = 0;

    spin(3'd5, 3'd6, 3'd1, 0, 0);
    spin(3'd7, 3'd7, 3'd7, 3, 5000);
    spin(3'd3, 3'd3, 3'd3, 2, 500);
    spin(3'd2, 3'd4, 3'd2, 1, 50);

    // Reset in the middle of SETTLE aborts the spin immediately.
    @(negedge clk); button = 1'b1;
    repeat (3) @(negedge clk); button = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_active", a_spin_active, 1);
    reset = 1'b1;
    #1;
    chk("abort_a_credits", a_credits, 1000);
    chk("abort_c_credits", c_credits, 8000);
    chk("abort_active", a_spin_active, 0);
    chk("abort_counts", {a_spin_count, a_win_count}, 0);
    chk("abort_result", {a_win_code, a_payout, a_result_valid}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (a_result_valid) rv_seen++;
    end
    chk("no_rv_after_abort", rv_seen, 0);
    $display("abort: credits A=%0d spin_count=%0d", a_credits, a_spin_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
